// File: rtl/data_mem_drain.sv
// Store-queue drain into a single-port data RAM, arbitrated against loads.
// Optional starvation guard (forces a drain under load pressure): DMEM_STARVE_GUARD_EN.
module data_mem_drain #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int QUEUE        = 16,
    parameter int MEM_DEPTH    = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  commit_store,
    output logic                  store_valid,
    input  logic                  mem_write_en,
    input  logic [ADDR_WIDTH-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  load_req,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    output logic                  load_ready,
    output logic                  load_rvalid,
    output logic [DATA_WIDTH-1:0] load_rdata,
    output logic                  overflow
);

    localparam int IW = $clog2(MEM_DEPTH);
    localparam int PW = $clog2(QUEUE + 1);

    logic [PW-1:0]         pending;
    logic                  write_slot;
    logic                  starve_hit;
    logic                  load_accept;
    logic                  commit_full;
    logic [IW-1:0]         widx;
    logic [IW-1:0]         ridx;
    logic                  unused_addr;
    logic [DATA_WIDTH-1:0] ram [MEM_DEPTH];

    // Byte addresses: only the word index reaches the RAM.
    assign widx        = mem_waddr[IW+1:2];
    assign ridx        = load_addr[IW+1:2];
    assign unused_addr = ^{mem_waddr, load_addr};

    always_comb begin
        store_valid = (pending != '0) && !flush && (!load_req || starve_hit);
    end

    assign load_ready  = !write_slot;
    assign load_accept = load_req && load_ready;
    assign commit_full = commit_store && !store_valid && (pending == PW'(QUEUE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= '0;
            write_slot <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            write_slot <= store_valid;
            if (commit_full)
                overflow <= 1'b1;
            if (flush)
                pending <= '0;
            else if (commit_store && !store_valid && !commit_full)
                pending <= pending + PW'(1);
            else if (!commit_store && store_valid)
                pending <= pending - PW'(1);
        end
    end

`ifdef DMEM_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (flush || store_valid)
            starve_cnt <= '0;
        else if ((pending != '0) && (starve_cnt < SW'(STARVE_LIMIT)))
            starve_cnt <= starve_cnt + SW'(1);
    end

    assign starve_hit = (starve_cnt >= SW'(STARVE_LIMIT));
`else
    assign starve_hit = 1'b0;
`endif

    // The write strobe is authoritative even without a matching write_slot.
    always_ff @(posedge clk) begin
        if (mem_write_en)
            ram[widx] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_rvalid <= 1'b0;
            load_rdata  <= '0;
        end else begin
            load_rvalid <= load_accept;
            if (load_accept)
                load_rdata <= ram[ridx];
        end
    end

endmodule

// File: tb/tb_data_mem_drain.sv
// Randomized and directed bench for data_mem_drain against a behavioural model
// (pending count, sparse memory map, load pipeline); honours DMEM_STARVE_GUARD_EN.
module tb_data_mem_drain;

    localparam int QUEUE = 16;
    localparam int LIMIT = 4;
`ifdef DMEM_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, commit_store, store_valid, mem_write_en;
    logic        load_req, load_ready, load_rvalid, overflow;
    logic [31:0] mem_waddr, mem_wdata, load_addr, load_rdata;

    data_mem_drain #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .QUEUE       (QUEUE),
        .MEM_DEPTH   (1024),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .commit_store(commit_store),
        .store_valid (store_valid),
        .mem_write_en(mem_write_en),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .load_req    (load_req),
        .load_addr   (load_addr),
        .load_ready  (load_ready),
        .load_rvalid (load_rvalid),
        .load_rdata  (load_rdata),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    // Reference model state
    int          m_pend, m_starve;
    bit          m_wslot, m_rv, m_ovf, m_rd_known;
    logic [31:0] m_rd;
    logic [31:0] m_mem [int];
    wr_t         wq[$];

    int n_checks = 0;
    int n_pass   = 0;
    int sv_seen  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int word_index(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom & 32'hFFFF_F003;
        a[5:2] = 4'($urandom_range(0, 15));
        return a;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        commit_store = 1'b0;
        load_req     = 1'b0;
        flush        = 1'b0;
        mem_write_en = 1'b0;
        #1;
        m_pend = 0; m_starve = 0; m_wslot = 0; m_rv = 0; m_ovf = 0;
        m_rd = '0; m_rd_known = 1;
        wq.delete();
        check("rst_rvalid", load_rvalid, 0);
        check("rst_rdata", load_rdata, 0);
        check("rst_overflow", overflow, 0);
        check("rst_store_valid", store_valid, 0);
        check("rst_load_ready", load_ready, 1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input bit c, input bit lr, input logic [31:0] la, input bit fl,
                        input bit spur = 1'b0);
        bit          sv_e, acc, wen, full;
        logic [31:0] wa, wd;
        wr_t         w;
        int          ridx, widx, pend_old;
        @(negedge clk);
        wen = m_wslot || spur;
        wa  = rand_addr();
        wd  = $urandom;
        if (m_wslot && wq.size() > 0) begin
            w  = wq.pop_front();
            wa = w.a;
            wd = w.d;
        end
        commit_store = c;
        load_req     = lr;
        load_addr    = la;
        flush        = fl;
        mem_write_en = wen;
        mem_waddr    = wa;
        mem_wdata    = wd;
        #1;
        sv_e = (m_pend != 0) && !fl && (!lr || (GUARD && m_starve >= LIMIT));
        check("store_valid", store_valid, sv_e);
        check("load_ready", load_ready, !m_wslot);
        if (store_valid === 1'b1)
            sv_seen++;
        acc  = lr && !m_wslot;
        ridx = word_index(la);
        widx = word_index(wa);
        @(posedge clk);
        #1;
        m_rv = acc;
        if (acc) begin
            // same-cycle read/write of one word is not a defined ordering; skip it
            if (m_mem.exists(ridx) && !(wen && widx == ridx)) begin
                m_rd = m_mem[ridx];
                m_rd_known = 1;
            end else begin
                m_rd_known = 0;
            end
        end
        if (wen)
            m_mem[widx] = wd;
        pend_old = m_pend;
        full = c && !sv_e && (m_pend == QUEUE);
        if (full)
            m_ovf = 1;
        if (fl)
            m_pend = 0;
        else if (!full)
            m_pend = m_pend + int'(c) - int'(sv_e);
        if (fl || sv_e)
            m_starve = 0;
        else if (pend_old != 0)
            m_starve++;
        m_wslot = sv_e;
        check("load_rvalid", load_rvalid, m_rv);
        check("overflow", overflow, m_ovf);
        if (m_rd_known)
            check("load_rdata", load_rdata, m_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 0; commit_store = 0; load_req = 0; mem_write_en = 0;
        load_addr = '0; mem_waddr = '0; mem_wdata = '0;

        // Three commits, no loads: three consecutive pops feeding 0x10/0x14/0x18
        do_reset();
        wq.push_back(wr_t'{a: 32'h10, d: 32'hAAAA_0001});
        wq.push_back(wr_t'{a: 32'h14, d: 32'hBBBB_0002});
        wq.push_back(wr_t'{a: 32'h18, d: 32'hCCCC_0003});
        sv_seen = 0;
        repeat (3) step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        check("drain3_pops", sv_seen, 3);
        step(0, 1, 32'h14, 0);
        check("load14_rvalid", load_rvalid, 1);
        check("load14_rdata", load_rdata, 32'hBBBB_0002);
        step(0, 1, 32'h13, 0);
        check("load13_low_bits_ignored", load_rdata, 32'hAAAA_0001);
        step(0, 0, 0, 0);
        check("rdata_hold", load_rdata, 32'hAAAA_0001);

        // pending=2 under a continuous load stream
        do_reset();
        step(1, 1, 32'h10, 0);
        step(1, 1, 32'h10, 0);
        sv_seen = 0;
        repeat (10) step(0, 1, 32'h18, 0);
        check("starve_pops", sv_seen, GUARD ? 2 : 0);

        // 17 commits with pops blocked by loads
        do_reset();
        repeat (17) step(1, 1, 32'h10, 0);
`ifndef DMEM_STARVE_GUARD_EN
        check("ovf_set", overflow, 1);
`endif
        sv_seen = 0;
        repeat (20) step(0, 0, 0, 0);
`ifndef DMEM_STARVE_GUARD_EN
        check("ovf_drain_pops", sv_seen, 16);
        check("ovf_sticky", overflow, 1);
`endif
        do_reset();

        // Flush right after a pop: in-flight write lands, nothing more drains
        repeat (3) step(1, 1, 32'h10, 0);
        wq.push_back(wr_t'{a: 32'h20, d: 32'hC0FF_EE30});
        step(0, 0, 0, 0);
        sv_seen = 0;
        step(0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0);
        check("flush_no_pop", sv_seen, 0);
        step(0, 1, 32'h20, 0);
        check("flush_write_landed", load_rdata, 32'hC0FF_EE30);

        // Commit and pop together at pending=1
        do_reset();
        step(1, 0, 0, 0);
        sv_seen = 0;
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        check("commit_pop_same_cycle", sv_seen, 2);

        // Randomized traffic with occasional stray strobes and mid-run resets
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0)
                do_reset();
            else
                step($urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1, rand_addr(),
                     $urandom_range(0, 24) == 0,
                     !m_wslot && ($urandom_range(0, 29) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_drain.md
DATA_MEM_DRAIN -- requirements
Module: data_mem_drain

Interface
REQ-001 Parameters: ADDR_WIDTH, default 32, byte-address width.
REQ-002 Parameters: DATA_WIDTH, default 32, word width.
REQ-003 Parameters: QUEUE, default 16, store-queue capacity tracked by the pending counter.
REQ-004 Parameters: MEM_DEPTH, default 1024, number of words in the internal single-port data RAM (power of two).
REQ-005 Parameters: STARVE_LIMIT, default 4, number of deferred cycles before a store drain is forced.
REQ-006 The block SHALL use reset rst, asynchronous, active-high, and clock clk.
REQ-007 Ports, in order:
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- flush  in  1  pipeline flush; clears the pending count and suppresses pops.
- commit_store  in  1  one pulse per store entered into the store queue.
- store_valid  out  1  pop request to the store queue.
- mem_write_en  in  1  store-queue write strobe, one cycle after store_valid.
- mem_waddr  in  ADDR_WIDTH  store byte address.
- mem_wdata  in  DATA_WIDTH  store data.
- load_req  in  1  load request.
- load_addr  in  ADDR_WIDTH  load byte address.
- load_ready  out  1  load accepted this cycle when load_req is also high.
- load_rvalid  out  1  load data valid.
- load_rdata  out  DATA_WIDTH  load data.
- overflow  out  1  sticky error flag: commit received while the pending count was QUEUE.

Function
REQ-008 The RAM SHALL be word-indexed by address bits [log2(MEM_DEPTH)+1:2]; address bits [1:0] are ignored.
REQ-009 The pending counter, $clog2(QUEUE+1) bits wide, SHALL update as follows:
- increment on commit_store;
- decrement on store_valid;
- both in the same cycle: count unchanged;
- commit_store at QUEUE without a pop: count holds and overflow is set.
REQ-010 store_valid SHALL be combinational, equal to (pending!=0) && !flush && (!load_req || starve_hit).
REQ-011 A store_valid pop SHALL never underflow the counter, since it requires pending!=0.
REQ-012 write_slot SHALL be store_valid registered; mem_write_en is expected high exactly in write_slot cycles.
REQ-013 When mem_write_en is high, the RAM SHALL write mem_wdata at mem_waddr that cycle, regardless of flush (the entry is already popped).
REQ-014 load_ready SHALL be !write_slot, because the write owns the single RAM port that cycle.
REQ-015 An accepted load (load_req && load_ready) SHALL produce load_rvalid=1 and load_rdata=RAM[index] on the next cycle (latency 1).
REQ-016 When no load is accepted, load_rvalid SHALL be 0 and load_rdata SHALL hold its last value.
REQ-017 A load accepted in cycle t SHALL observe any write performed in cycle t-1 or earlier.
REQ-018 Back-to-back pops SHALL be allowed, giving a store_valid and a mem_write_en in the same cycle.
REQ-019 flush SHALL clear the pending counter and the starvation counter next edge; store_valid is 0 during flush, and write_slot from a pre-flush pop still completes.
REQ-020 mem_write_en arriving without write_slot SHALL still write the RAM (the strobe is authoritative).

Reset
REQ-021 On rst, the following SHALL clear asynchronously: pending=0, write_slot=0, starvation counter=0, load_rvalid=0, load_rdata=0, overflow=0.
REQ-022 RAM contents SHALL NOT be reset and are undefined until written.
REQ-023 Deasserting rst mid-operation SHALL resume from the idle state; pops lost to reset are not replayed.

Configuration
REQ-024 Macro DMEM_STARVE_GUARD_EN defined: the starvation counter SHALL behave as follows:
- increment each cycle with pending!=0 && !store_valid;
- clear on store_valid;
- starve_hit=(counter>=STARVE_LIMIT).
REQ-025 Macro DMEM_STARVE_GUARD_EN not defined: starve_hit SHALL be constant 0 and no counter logic exists, so loads always win and a continuous load_req stream blocks draining indefinitely.

Verification
REQ-026 Reset, then 3 commit_store pulses with no loads -> store_valid high 3 consecutive cycles, then 0; feed writes 0x10=A, 0x14=B, 0x18=C; pending=0.
REQ-027 After REQ-026, load_addr=0x14 -> load_rvalid next cycle with load_rdata=B; load_ready low in each write_slot cycle.
REQ-028 pending=2 with load_req held high for 10 cycles and guard enabled -> store_valid forced after 4 deferred cycles; guard disabled -> no store_valid for all 10 cycles.
REQ-029 commit_store 17 times, no pops -> pending=16, overflow=1 and sticky until rst.
REQ-030 flush in the cycle after a pop, with pending=3 -> the in-flight write lands, pending=0, no further store_valid.
REQ-031 Simultaneous commit_store and store_valid at pending=1 -> pending remains 1.
